// File: rtl/fifo_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_sched
//  Description : Read-side scheduler for an async FIFO. Shares the single
//                FIFO read port among NREQ consumers using round-robin
//                arbitration with a bounded burst per grant. Drives the FIFO
//                pop strobe from the granted consumer's request (gated by
//                empty) and returns each popped word, registered, to the
//                consumer that owns the grant.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREQ        number of consumers (2..8)
//    DATA_WIDTH  FIFO word width
//    MAX_BURST   maximum pops per grant (>=1)
//  Ports
//    rclk_i      read-domain clock, rising edge
//    rst_n_i     asynchronous active-low reset
//    req_i       per-consumer level read request
//    empty_i     FIFO empty flag (read domain)
//    rdata_i     FIFO first-word-fall-through read data
//    rinc_o      FIFO pop strobe (combinational)
//    gnt_o       one-hot current grant, zero when idle (registered)
//    busy_o      high while a burst is in progress
//    dvalid_o    one-hot: dout_o is valid for that consumer (registered)
//    dout_o      most recently popped word (registered)
// ============================================================================
module fifo_rd_sched #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  rclk_i,
    input  logic                  rst_n_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  rinc_o,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  busy_o,
    output logic [NREQ-1:0]       dvalid_o,
    output logic [DATA_WIDTH-1:0] dout_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;

    localparam logic [CW-1:0]   C_CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0]   C_CNT_ONE  = CW'(1);
    localparam logic [IW-1:0]   C_LAST_RST = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] C_GNT_ONE  = NREQ'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    state_t                  state_q,  state_d;
    logic [NREQ-1:0]         gnt_q,    gnt_d;
    logic [IW-1:0]           last_q,   last_d;
    logic [CW-1:0]           cnt_q,    cnt_d;
    logic [NREQ-1:0]         dvalid_q, dvalid_d;
    logic [DATA_WIDTH-1:0]   dout_q,   dout_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    req_g;      // request of the granted consumer
    logic                    pop;        // a FIFO pop happens on this edge
    logic                    win_found;
    logic [IW-1:0]           win_idx;
    logic [IW-1:0]           cand;

    // gnt_q is all-zero outside a burst, so masking req_i with it both
    // selects the granted request and forces rinc low while idle. This
    // keeps rinc a function of gnt, req and empty only.
    assign req_g  = |(gnt_q & req_i);
    assign pop    = req_g & ~empty_i;
    assign rinc_o = pop;

    // Round-robin search: first set request starting just after the most
    // recent winner, wrapping modulo NREQ. Offset NREQ lands back on the
    // previous winner, so a lone requester can be re-granted.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        dvalid_d = '0;
        dout_d   = dout_q;

        case (state_q)
            ST_IDLE: begin
                // The idle cycle is the arbitration bubble between bursts.
                if (win_found && !empty_i) begin
                    state_d = ST_BURST;
                    gnt_d   = C_GNT_ONE << win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                end
            end

            ST_BURST: begin
                if (pop) begin
                    cnt_d    = cnt_q + C_CNT_ONE;
                    dout_d   = rdata_i;
                    dvalid_d = gnt_q;
                end
                // Release on burst limit, request withdrawal or FIFO empty.
                // A pop on the releasing edge is still delivered above.
                if ((pop && (cnt_q == C_CNT_LAST)) || !req_g || empty_i) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge rclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            last_q   <= C_LAST_RST;
            cnt_q    <= '0;
            dvalid_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            dvalid_q <= dvalid_d;
            dout_q   <= dout_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign busy_o   = (state_q == ST_BURST);
    assign dvalid_o = dvalid_q;
    assign dout_o   = dout_q;

endmodule
`default_nettype wire

// File: doc/fifo_rd_sched.md
# fifo_rd_sched

Read-side scheduler for the async FIFO: shares the single FIFO read port (read-clock domain, after the empty flag logic) among NREQ consumers. It uses round-robin arbitration with a bounded burst per grant. It drives the FIFO pop strobe `rinc` from the winning consumer's request, qualified by `empty`. It returns each popped word, registered, to the consumer that owns the grant.

## Interface
- NREQ, 4, number of consumers (2..8)
- DATA_WIDTH, 8, FIFO word width
- MAX_BURST, 4, max pops per grant (>=1); burst counter width CW = $clog2(MAX_BURST)+1
- rclk  in  1  read-domain clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-consumer read request, level, one bit per consumer
- empty  in  1  FIFO empty flag (registered, read domain)
- rdata  in  DATA_WIDTH  FIFO read data for current read address (first-word-fall-through)
- rinc  out  1  FIFO pop strobe, combinational
- gnt  out  NREQ  one-hot current grant, registered; all-zero when idle
- busy  out  1  high while in BURST state
- dvalid  out  NREQ  one-hot: dout is valid for that consumer this cycle, registered
- dout  out  DATA_WIDTH  popped word, registered

## Operation
- FSM states: IDLE, BURST. Registers: state, gnt, last (index of most recent winner), cnt (pops in current burst), dvalid, dout.
- Reset values: state=IDLE, gnt=0, busy=0, rinc=0, last=NREQ-1 (consumer 0 has first priority), cnt=0, dvalid=0, dout=0.
- IDLE:
  - gnt=0, rinc=0.
  - If (|req) & ~empty: the winner is the first set bit of req searching last+1, last+2, … modulo NREQ.
  - Next edge: gnt<=onehot(winner), last<=winner, cnt<=0, state<=BURST.
  - Otherwise stay in IDLE.
- BURST, with g = granted index:
  - rinc = req[g] & ~empty; a pop occurs on an edge where rinc=1.
  - On a pop: cnt<=cnt+1, dout<=rdata, dvalid<=gnt.
  - On a non-pop cycle: dvalid<=0 and dout holds its value.
- Exit BURST to IDLE (gnt<=0 on the same edge) when any of these holds:
  - a pop with cnt==MAX_BURST-1;
  - ~req[g];
  - empty.
- The exit-cycle pop, if any, is still delivered.
- IDLE lasts at least one cycle between bursts (the arbitration bubble). A continuously requesting consumer therefore gets at most MAX_BURST words per MAX_BURST+1 cycles.
- Requests from non-granted consumers are ignored until the next IDLE.
- Fairness: last advances only on a grant. A consumer with req held waits at most NREQ-1 bursts.
- MAX_BURST=1: every grant is exactly one pop or zero pops.
- Boundary conditions:
  - empty rising mid-burst: no pop that cycle; release to IDLE.
  - req[g] dropping: release without a pop that cycle.
  - Pops never occur while empty=1 (rinc is gated).
- Reset asserted mid-burst: all registers return to reset values asynchronously; rinc drops to 0 immediately; any in-flight word is discarded.

## Timing
- Request to first pop: req rises at edge N (FIFO non-empty, scheduler IDLE), gnt is visible after edge N+1, rinc is high in cycle N+1, and the pop occurs at edge N+2.
- Pop to data: the word popped at edge k appears on dout with dvalid after edge k, for one cycle per pop.
- Back-to-back pops within a burst: one per cycle, no bubbles.
- Timing paths: rinc depends combinationally on gnt, req and empty only, with no path from rdata. All other outputs are flop outputs.

## Test plan
- **Single consumer, FIFO holds 6 words (A0..A5), req[0]=1, MAX_BURST=4:**
  - gnt=0001, then 4 consecutive pops with dout A0..A3 and dvalid=0001.
  - 1 IDLE cycle, then regrant, 2 pops (A4, A5).
  - empty goes high, release, gnt=0 and the FIFO is left empty.
- **All four consumers requesting, FIFO kept non-empty:**
  - Grant order is 0,1,2,3,0, each with 4 pops.
  - dvalid one-hot tracks the granted consumer.
  - Never two grants at once.
- **Priority rotation:** last=1 with req=1001. Winner is 3, then 0 on the next arbitration.
- **Request drop mid-burst:** consumer 2 drops req after 2 pops. It releases that cycle (no pop), cnt resets, and the next requester is granted after the 1-cycle IDLE.
- **FIFO empty with req=1111:** gnt stays 0, rinc stays 0, dvalid stays 0. When empty falls, consumer 0 is granted on the next edge.
- **Reset mid-burst** (asserted after pop 2):
  - Immediately: rinc=0, gnt=0, dvalid=0, dout=0.
  - After release: consumer 0 is granted first.
